// File: rtl/mux_n_to_1_stream.sv
// Registered N-to-1 stream multiplexer with select or round-robin channel choice.
// Each output beat carries the index of the channel it came from.
module mux_n_to_1_stream #(
  parameter int unsigned N = 9,
  parameter int unsigned W = 8,
  parameter int unsigned M = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N*W-1:0] in_data_i,
  input  logic [N-1:0]   in_valid_i,
  output logic [N-1:0]   in_ready_o,
  input  logic [M-1:0]   sel_i,
  input  logic           rr_en_i,
  output logic [W-1:0]   out_data_o,
  output logic [M-1:0]   out_chan_o,
  output logic           out_valid_o,
  input  logic           out_ready_i
);

  localparam int unsigned NumIdx = 2 ** M;

  logic [W-1:0]      data_q, data_d;
  logic [M-1:0]      chan_q, chan_d;
  logic              valid_q, valid_d;
  logic [M-1:0]      ptr_q, ptr_d;

  logic              load;
  logic              sel_vld;
  logic              rr_vld, hi_vld, lo_vld;
  logic [M-1:0]      rr_gnt, hi_gnt, lo_gnt;
  logic [M-1:0]      gnt;
  logic              grant_vld;
  logic              xfer;
  logic [W-1:0]      gnt_data;
  logic [NumIdx-1:0] valid_pad;

  assign load = !valid_q || out_ready_i;

  // Padding lets an out-of-range select index the valid vector safely.
  assign valid_pad = NumIdx'(in_valid_i);
  assign sel_vld   = (32'(sel_i) < N) && valid_pad[sel_i];

  // Lowest valid channel at or above ptr wins; otherwise lowest valid below ptr.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_gnt = '0;
    lo_gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid_i[i]) begin
        if (32'(i) >= 32'(ptr_q)) begin
          hi_vld = 1'b1;
          hi_gnt = M'(i);
        end else begin
          lo_vld = 1'b1;
          lo_gnt = M'(i);
        end
      end
    end
    rr_vld = hi_vld || lo_vld;
    rr_gnt = hi_vld ? hi_gnt : lo_gnt;
  end

  assign gnt       = rr_en_i ? rr_gnt : sel_i;
  assign grant_vld = rr_en_i ? rr_vld : sel_vld;
  assign xfer      = !rst_i && load && grant_vld;

  always_comb begin
    gnt_data   = '0;
    in_ready_o = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == M'(i)) begin
        gnt_data      = in_data_i[i*W +: W];
        in_ready_o[i] = xfer;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = xfer;
      if (xfer) begin
        data_d = gnt_data;
        chan_d = gnt;
      end
    end
    if (xfer && rr_en_i) begin
      ptr_d = (32'(gnt) == N - 1) ? '0 : gnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_chan_o  = chan_q;
  assign out_valid_o = valid_q;

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Scoreboard bench for mux_n_to_1_stream: directed scenarios then random traffic,
// with expected beats queued at issue time and checked by an independent monitor.
module tb_mux_n_to_1_stream;

  localparam int unsigned N = 9;
  localparam int unsigned W = 8;
  localparam int unsigned M = 4;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [M-1:0]   sel;
  logic           rr_en;
  logic [W-1:0]   out_data;
  logic [M-1:0]   out_chan;
  logic           out_valid;
  logic           out_ready;

  mux_n_to_1_stream #(.N(N), .W(W), .M(M)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sel_i       (sel),
    .rr_en_i     (rr_en),
    .out_data_o  (out_data),
    .out_chan_o  (out_chan),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [W+M-1:0] exp_q[$];

  // Reference state: whether a beat sits in the output stage, and the fairness pointer.
  bit m_ov  = 1'b0;
  int m_ptr = 0;
  bit known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_grant(input logic [N-1:0] v, input int s, input bit rr,
                                      input int ptr, output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (!rr) begin
      g = s;
      if (s < N) gv = v[s];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (!gv && v[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  // Called at posedge+2; drives one cycle of inputs and returns at the next posedge+2.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic [M-1:0] s, input bit rr, input logic ord);
    bit             load, gv, xfer;
    int             g;
    logic [N-1:0]   exp_rdy;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    sel       = s;
    rr_en     = rr;
    out_ready = ord;
    #1;
    if (known) check("out_valid", 32'(out_valid), 32'(m_ov));
    load = !m_ov || ord;
    model_grant(v, int'(s), rr, m_ptr, gv, g);
    xfer    = !r && load && gv;
    exp_rdy = '0;
    if (xfer) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (r) exp_q.delete();
    if (xfer) exp_q.push_back({d[g*W +: W], M'(g)});
    @(posedge clk);
    if (r) begin
      m_ov  = 1'b0;
      m_ptr = 0;
      known = 1'b1;
    end else if (load) begin
      m_ov = xfer;
      if (xfer && rr) m_ptr = (g + 1) % N;
    end
    #2;
  endtask

  // Monitor: a beat is consumed when valid and ready are both high before the edge.
  initial begin
    logic [W+M-1:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(out_chan), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(e[W+M-1:M]));
          check("beat_chan", 32'(out_chan), 32'(e[M-1:0]));
        end
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    rst = 1'b1; in_valid = '0; in_data = '0; sel = '0; rr_en = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #2;

    // Reset with every channel valid, then first beat in select mode
    repeat (2) begin
      step(1'b1, '1, rand_data(), 4'd3, 1'b0, 1'b1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_chan", 32'(out_chan), 32'd0);
    end
    step(1'b0, '1, rand_data(), 4'd3, 1'b0, 1'b1);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_chan", 32'(out_chan), 32'd3);

    // Select highest channel, then an out-of-range select
    d = rand_data();
    d[8*W +: W] = 8'hA5;
    step(1'b0, 9'h100, d, 4'd8, 1'b0, 1'b1);
    check("sel8_data", 32'(out_data), 32'hA5);
    check("sel8_chan", 32'(out_chan), 32'd8);
    step(1'b0, '1, rand_data(), 4'd12, 1'b0, 1'b1);
    check("sel12_valid", 32'(out_valid), 32'd0);

    // Backpressure holds the registered beat
    d = rand_data();
    d[2*W +: W] = 8'h11;
    step(1'b0, 9'h004, d, 4'd2, 1'b0, 1'b1);
    repeat (3) begin
      step(1'b0, '1, rand_data(), 4'd2, 1'b0, 1'b0);
      check("bp_data", 32'(out_data), 32'h11);
      check("bp_chan", 32'(out_chan), 32'd2);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    step(1'b0, '1, rand_data(), 4'd5, 1'b0, 1'b1);
    check("bp_release_chan", 32'(out_chan), 32'd5);

    // Round-robin fairness from a fresh pointer
    step(1'b1, '0, rand_data(), 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, '1, rand_data(), 4'd0, 1'b1, 1'b1);
      check("rr_fair_chan", 32'(out_chan), 32'(i % N));
      check("rr_fair_valid", 32'(out_valid), 32'd1);
    end

    // Skip and wrap: move pointer to 7, then only ch1 and ch4 request
    step(1'b0, 9'h040, rand_data(), 4'd0, 1'b1, 1'b1);
    check("rr_to7_chan", 32'(out_chan), 32'd6);
    step(1'b0, 9'h012, rand_data(), 4'd0, 1'b1, 1'b1);
    check("rr_wrap_chan", 32'(out_chan), 32'd1);
    step(1'b0, 9'h012, rand_data(), 4'd0, 1'b1, 1'b1);
    check("rr_skip_chan", 32'(out_chan), 32'd4);
    step(1'b0, '1, rand_data(), 4'd0, 1'b1, 1'b1);
    check("rr_ptr5_chan", 32'(out_chan), 32'd5);

    // Pointer survives a detour through select mode
    step(1'b0, 9'h004, rand_data(), 4'd0, 1'b1, 1'b1);
    check("rr_to3_chan", 32'(out_chan), 32'd2);
    repeat (2) begin
      step(1'b0, '1, rand_data(), 4'd0, 1'b0, 1'b1);
      check("mode_sel_chan", 32'(out_chan), 32'd0);
    end
    step(1'b0, '1, rand_data(), 4'd0, 1'b1, 1'b1);
    check("mode_back_chan", 32'(out_chan), 32'd3);

    // Random traffic
    repeat (600) begin
      step(($urandom_range(0, 49) == 0), N'($urandom), rand_data(), M'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    repeat (3) step(1'b0, '0, rand_data(), 4'd0, 1'b0, 1'b1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
